// File: rtl/req_arbiter4.sv
// Round-robin arbiter/sequencer for a shared 4-way mux: level or single-shot requesters,
// minimum grant tenure, one-hot grant, mux select and select-change strobe.
module req_arbiter4 #(
    parameter int HOLD_CYCLES = 4   // minimum grant tenure, 1..16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req_i,
    input  logic [3:0] ss_mode_i,
    output logic [1:0] sel_o,
    output logic [3:0] gnt_o,
    output logic       gnt_valid_o,
    output logic       sel_changed_o
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYCLES - 1);

    state_t     state_q, state_d;
    logic [3:0] hold_q, hold_d;
    logic [1:0] rr_ptr_q, rr_ptr_d;
    logic [3:0] gnt_q, gnt_d;
    logic [1:0] sel_q, sel_d;
    logic       sel_changed_q, sel_changed_d;
    logic [3:0] ss_pend_q, ss_pend_d;
    logic [3:0] req_q;

    logic [3:0] pend;
    logic [1:0] cand_idx [4];
    logic [3:0] cand_hit;
    logic       win_found;
    logic [1:0] win_idx;
    logic       issue;

    // A stale ss_pend bit is masked (not cleared) while its requester is in level mode.
    assign pend = (ss_mode_i & ss_pend_q) | (~ss_mode_i & req_i);

    // Candidate k is rr_ptr+k+1, so the previous owner (== rr_ptr) is searched last.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_cand
            assign cand_idx[gi] = rr_ptr_q + 2'(gi + 1);
            assign cand_hit[gi] = pend[cand_idx[gi]];
        end
    endgenerate

    always_comb begin
        win_found = 1'b0;
        win_idx   = rr_ptr_q;
        for (int k = 3; k >= 0; k--) begin
            if (cand_hit[k]) begin
                win_found = 1'b1;
                win_idx   = cand_idx[k];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        hold_d        = hold_q;
        rr_ptr_d      = rr_ptr_q;
        gnt_d         = gnt_q;
        sel_d         = sel_q;
        sel_changed_d = 1'b0;
        issue         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    issue = 1'b1;
                end
            end
            ST_BUSY: begin
                if (hold_q != 4'd0) begin
                    hold_d = hold_q - 4'd1;
                end else if (win_found) begin
                    issue = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                    gnt_d   = 4'b0000;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = 4'b0000;
            end
        endcase
        if (issue) begin
            state_d       = ST_BUSY;
            hold_d        = HOLD_LOAD;
            rr_ptr_d      = win_idx;
            gnt_d         = 4'b0001 << win_idx;
            sel_d         = win_idx;
            sel_changed_d = (win_idx != sel_q);
        end
    end

    // Sticky single-shot capture; a new rising edge beats the grant clear at the same edge.
    generate
        for (gi = 0; gi < 4; gi++) begin : g_ss
            logic ss_set;
            logic ss_clr;
            assign ss_set = ss_mode_i[gi] & req_i[gi] & ~req_q[gi];
            assign ss_clr = ss_mode_i[gi] & issue & (win_idx == 2'(gi));
            assign ss_pend_d[gi] = ss_set | (ss_pend_q[gi] & ~ss_clr);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            hold_q        <= 4'd0;
            rr_ptr_q      <= 2'd3;
            gnt_q         <= 4'b0000;
            sel_q         <= 2'd0;
            sel_changed_q <= 1'b0;
            ss_pend_q     <= 4'b0000;
            req_q         <= 4'b0000;
        end else begin
            state_q       <= state_d;
            hold_q        <= hold_d;
            rr_ptr_q      <= rr_ptr_d;
            gnt_q         <= gnt_d;
            sel_q         <= sel_d;
            sel_changed_q <= sel_changed_d;
            ss_pend_q     <= ss_pend_d;
            req_q         <= req_i;
        end
    end

    assign sel_o         = sel_q;
    assign gnt_o         = gnt_q;
    assign gnt_valid_o   = |gnt_q;
    assign sel_changed_o = sel_changed_q;

`ifndef SYNTHESIS
    a_gnt_onehot0 : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt_o));
    a_gnt_valid   : assert property (@(posedge clk) disable iff (!rst_n) gnt_valid_o == (|gnt_o));
    a_gnt_sel     : assert property (@(posedge clk) disable iff (!rst_n) (gnt_o != 4'b0000) |-> gnt_o[sel_o]);
`endif

endmodule
